calc_host_seq: RTL and testbench
================================

// Module: calc_host_seq
// PURPOSE
// - Initiator-side sequencer for the two-operand calculator (Go/Op/in1/in2 in, out/Done back).
// - Accepts operation requests on a valid/ready command port and drives the calculator's Go pulse.
// - Holds the operands and Op stable until Done is seen, then captures out onto a valid/ready result port.
// - Flags a timeout if Done never arrives. Sits between test/UI logic and the calculator top level.
// PARAMETERS
// - DW       3    operand/result width (matches calculator in1/in2/out)
// - OPW      2    opcode width
// - TIMEOUT  64   max cycles in WAIT before abort (>=2)
// - CNTW     8    width of the completed-operation counter
// PORTS
// - clk        in   1     single clock, rising edge
// - rst        in   1     asynchronous, active-high reset
// - cmd_valid  in   1     command present
// - cmd_ready  out  1     sequencer can take a command
// - cmd_op     in   OPW   opcode
// - cmd_a      in   DW    operand 1
// - cmd_b      in   DW    operand 2
// - go         out  1     to calculator Go
// - op         out  OPW   to calculator Op
// - in1, in2   out  DW    to calculator in1/in2
// - done       in   1     from calculator Done (level, may stay high several cycles)
// - result     in   DW    from calculator out
// - res_valid  out  1     result available
// - res_ready  in   1     consumer takes result
// - res_data   out  DW    captured result
// - res_op     out  OPW   opcode that produced res_data
// - res_err    out  1     1 = timeout abort; res_data = 0
// - busy       out  1     state != IDLE
// - op_count   out  CNTW  completed (non-error) operations, wraps at 2^CNTW
// BEHAVIOUR
// - Reset: state=IDLE; go=0, op/in1/in2=0, res_valid=0, res_data=0, res_op=0, res_err=0, op_count=0, timer=0.
// - cmd_ready = (state==IDLE) && !res_valid; accept on cmd_valid&&cmd_ready: latch op/in1/in2 -> ISSUE.
// - IDLE: wait for accept. done ignored.
// - ISSUE: go=1 exactly one cycle; next WAIT. Latency accept->go = 1 cycle.
// - WAIT: go=0; op/in1/in2 held. timer increments each cycle.
//   - A Done rising edge (done=1, done_q=0) captures result->res_data, op->res_op, res_err=0,
//     res_valid=1, op_count+1 -> DRAIN. done must go low before the next command is issued.
//   - A level-high done carried over from an earlier operation is not a completion.
//   - timer reaching TIMEOUT-1 with no edge: res_err=1, res_data=0, res_valid=1, count unchanged -> DRAIN.
//   - Edge and timeout in the same cycle: the edge wins.
// - DRAIN: wait for done=0 (calculator back in its idle state) -> IDLE; timer cleared.
// - Result port: res_valid stays high with data stable until res_valid&&res_ready, then cleared next cycle.
//   A new command is not accepted while res_valid=1 (single result register, no overwrite).
// - res_ready with res_valid=0: no effect.
// - done_q is a registered copy of done. It is reset to 1 so a done held high through reset is not seen as an edge.
// - rst asserted mid-operation: immediate return to reset values. go drops asynchronously; the pending result is lost.
// - op_count wraps from 2^CNTW-1 to 0 silently.
// TESTING
// - Single op: cmd op=2'b00 a=3 b=2, model Done 4 cycles after go -> go one cycle, in1=3/in2=2 held, res_data=model out, op_count=1.
// - Backpressure: res_ready=0 for 10 cycles after a result -> res_valid/res_data stable, cmd_ready=0; res_ready=1 -> cmd_ready=1 once done low.
// - Timeout: TIMEOUT=8, calculator never asserts Done -> res_valid with res_err=1, res_data=0 at 8 cycles after go, op_count unchanged.
// - Sticky Done: Done held high 5 cycles and still high at the next issue -> no false capture; only the next rising edge completes.
// - Reset mid-WAIT: assert rst 2 cycles after go -> go=0, res_valid=0, busy=0 at once; next command works normally.
// - Back-to-back: 4 commands with res_ready=1 (all four opcodes, a=7 b=7 overflow case) -> 4 results in order, res_op matches, op_count=4.

Source files
------------

// File: rtl/calc_host_seq.sv
// Initiator-side sequencer for the two-operand calculator: takes commands on a
// valid/ready port, pulses Go, waits for a Done rising edge (or times out) and presents the result.
module calc_host_seq #(
  parameter int DW      = 3,
  parameter int OPW     = 2,
  parameter int TIMEOUT = 64,
  parameter int CNTW    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [OPW-1:0]  cmd_op,
  input  logic [DW-1:0]   cmd_a,
  input  logic [DW-1:0]   cmd_b,
  output logic            go,
  output logic [OPW-1:0]  op,
  output logic [DW-1:0]   in1,
  output logic [DW-1:0]   in2,
  input  logic            done,
  input  logic [DW-1:0]   result,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [DW-1:0]   res_data,
  output logic [OPW-1:0]  res_op,
  output logic            res_err,
  output logic            busy,
  output logic [CNTW-1:0] op_count
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // Abort on the edge where the timer would step onto TIMEOUT-1.
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 2);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;

  state_t        state;
  logic          done_q;
  logic [TW-1:0] timer;
  logic          done_rise;

  assign cmd_ready = (state == S_IDLE) && !res_valid;
  assign busy      = (state != S_IDLE);
  assign done_rise = done && !done_q;

  // NOTE: all state below uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      // NOTE: done_q resets high so a Done held across reset is never taken as a fresh edge.
      done_q    <= 1'b1;
      timer     <= '0;
      go        <= 1'b0;
      op        <= '0;
      in1       <= '0;
      in2       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_op    <= '0;
      res_err   <= 1'b0;
      op_count  <= '0;
    end else begin
      done_q <= done;
      if (res_valid && res_ready) res_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op    <= cmd_op;
            in1   <= cmd_a;
            in2   <= cmd_b;
            go    <= 1'b1;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          go    <= 1'b0;
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (done_rise) begin
            res_data  <= result;
            res_op    <= op;
            res_err   <= 1'b0;
            res_valid <= 1'b1;
            op_count  <= op_count + 1'b1;
            state     <= S_DRAIN;
          end else if (timer == TLAST) begin
            timer     <= timer + 1'b1;
            res_data  <= '0;
            res_op    <= op;
            res_err   <= 1'b1;
            res_valid <= 1'b1;
            state     <= S_DRAIN;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_DRAIN: begin
          // The calculator must fall back to idle before the next Go.
          if (!done) begin
            timer <= '0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_host_seq.sv
// Scoreboard bench for calc_host_seq: the bench plays the calculator, pushes the expected
// result per command and a negedge monitor compares every result handshake.
module tb_calc_host_seq;

  localparam int DW = 3, OPW = 2, TMO = 8, CNTW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [OPW-1:0]  cmd_op = '0;
  logic [DW-1:0]   cmd_a = '0, cmd_b = '0;
  logic            go;
  logic [OPW-1:0]  op;
  logic [DW-1:0]   in1, in2;
  logic            done = 1'b0;
  logic [DW-1:0]   result = '0;
  logic            res_valid;
  logic            res_ready = 1'b1;
  logic [DW-1:0]   res_data;
  logic [OPW-1:0]  res_op;
  logic            res_err;
  logic            busy;
  logic [CNTW-1:0] op_count;

  calc_host_seq #(.DW(DW), .OPW(OPW), .TIMEOUT(TMO), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .go(go), .op(op), .in1(in1), .in2(in2),
    .done(done), .result(result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_op(res_op),
    .res_err(res_err), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]   data;
    logic [OPW-1:0]  op;
    logic            err;
    logic [CNTW-1:0] cnt;
  } exp_t;

  exp_t            sb[$];
  exp_t            mon_e;
  logic [CNTW-1:0] exp_cnt = '0;
  int              errors = 0;
  int              checks = 0;
  bit              rr_random = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Calculator behaviour: add, subtract, multiply, xor, all modulo 2^DW.
  function automatic logic [DW-1:0] calc(input logic [OPW-1:0] o, input logic [DW-1:0] a,
                                         input logic [DW-1:0] b);
    logic [DW-1:0] r;
    case (o)
      2'd0:    r = a + b;
      2'd1:    r = a - b;
      2'd2:    r = a * b;
      default: r = a ^ b;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every result handshake pops one expectation.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        check("unexpected result", res_valid, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        check("res_data", res_data, mon_e.data);
        check("res_op", res_op, mon_e.op);
        check("res_err", res_err, mon_e.err);
        check("op_count", op_count, mon_e.cnt);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rr_random) res_ready = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic send(input logic [OPW-1:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int n = 0;
    cmd_op = o; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin tick(); n++; end
    if (!cmd_ready) begin
      check("cmd_ready wait", cmd_ready, 1'b1);
      cmd_valid = 1'b0;
      return;
    end
    tick();
    cmd_valid = 1'b0;
    check("go after accept", go, 1'b1);
  endtask

  task automatic do_issue(input logic [OPW-1:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input bit err);
    exp_t e;
    if (!err) exp_cnt = exp_cnt + 1'b1;
    e.data = err ? '0 : calc(o, a, b);
    e.op   = o;
    e.err  = err;
    e.cnt  = exp_cnt;
    sb.push_back(e);
    send(o, a, b);
  endtask

  // Raise Done 'delay' cycles after the Go cycle, checking the operands are still held.
  task automatic respond(input int delay, input logic [OPW-1:0] o, input logic [DW-1:0] a,
                         input logic [DW-1:0] b);
    tick();
    check("go single cycle", go, 1'b0);
    repeat (delay - 1) tick();
    check("op held", op, o);
    check("in1 held", in1, a);
    check("in2 held", in2, b);
    result = calc(op, in1, in2);
    done   = 1'b1;
  endtask

  task automatic release_done(input int hold);
    repeat (hold) tick();
    done = 1'b0;
  endtask

  task automatic wait_res(output int n);
    n = 0;
    while (!res_valid && n < 20) begin tick(); n++; end
    check("result appears", res_valid, 1'b1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || res_valid) && n < 200) begin tick(); n++; end
    check("idle reached", busy | res_valid, 1'b0);
  endtask

  initial begin
    int n;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst go", go, 1'b0);
    check("rst op", op, 0);
    check("rst in1", in1, 0);
    check("rst in2", in2, 0);
    check("rst res_valid", res_valid, 1'b0);
    check("rst res_data", res_data, 0);
    check("rst res_op", res_op, 0);
    check("rst res_err", res_err, 1'b0);
    check("rst op_count", op_count, 0);
    check("rst busy", busy, 1'b0);
    check("rst cmd_ready", cmd_ready, 1'b1);
    rst = 1'b0;
    tick();

    // Single operation, Done four cycles after Go.
    do_issue(2'd0, 3'd3, 3'd2, 1'b0);
    respond(4, 2'd0, 3'd3, 3'd2);
    release_done(1);
    wait_idle();
    check("count after single op", op_count, 1);

    // Backpressure: result held, no new command until taken and Done low.
    res_ready = 1'b0;
    do_issue(2'd1, 3'd5, 3'd6, 1'b0);
    respond(3, 2'd1, 3'd5, 3'd6);
    wait_res(n);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp res_valid", res_valid, 1'b1);
      check("bp res_data", res_data, calc(2'd1, 3'd5, 3'd6));
      check("bp cmd_ready", cmd_ready, 1'b0);
    end
    res_ready = 1'b1;
    tick();
    check("bp cleared", res_valid, 1'b0);
    check("bp done still high", cmd_ready, 1'b0);
    done = 1'b0;
    tick();
    check("bp ready after done low", cmd_ready, 1'b1);

    // Timeout: Done never comes.
    do_issue(2'd2, 3'd4, 3'd3, 1'b1);
    wait_res(n);
    check("timeout latency", n, TMO);
    check("timeout res_err", res_err, 1'b1);
    wait_idle();

    // Done edge on the abort cycle wins.
    do_issue(2'd3, 3'd6, 3'd5, 1'b0);
    respond(TMO - 1, 2'd3, 3'd6, 3'd5);
    release_done(1);
    wait_idle();

    // Sticky Done: high before and across the issue, only the next rise completes.
    result = 3'd5;
    done   = 1'b1;
    tick(); tick();
    do_issue(2'd0, 3'd1, 3'd1, 1'b0);
    tick(); tick();
    check("sticky no capture", res_valid, 1'b0);
    check("sticky busy", busy, 1'b1);
    done = 1'b0;
    tick();
    check("sticky still waiting", res_valid, 1'b0);
    result = calc(op, in1, in2);
    done   = 1'b1;
    tick();
    check("sticky real edge", res_valid, 1'b1);
    release_done(1);
    wait_idle();

    // Reset two cycles after Go.
    do_issue(2'd1, 3'd2, 3'd3, 1'b0);
    tick(); tick();
    rst = 1'b1;
    #1;
    check("midrst go", go, 1'b0);
    check("midrst res_valid", res_valid, 1'b0);
    check("midrst busy", busy, 1'b0);
    check("midrst op_count", op_count, 0);
    sb.delete();
    exp_cnt = '0;
    tick();
    rst = 1'b0;
    tick();

    // Back-to-back, all opcodes, overflow operands.
    for (int i = 0; i < 4; i++) begin
      do_issue(OPW'(i), 3'd7, 3'd7, 1'b0);
      respond(2, OPW'(i), 3'd7, 3'd7);
      release_done(1);
    end
    wait_idle();
    check("back-to-back count", op_count, 4);

    // Random traffic with random consumer stalls; long enough to wrap op_count.
    rr_random = 1'b1;
    for (int i = 0; i < 270; i++) begin
      logic [OPW-1:0] o;
      logic [DW-1:0]  a, b;
      o = OPW'($urandom_range(0, 3));
      a = DW'($urandom_range(0, 7));
      b = DW'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) begin
        do_issue(o, a, b, 1'b1);
        wait_res(n);
      end else begin
        do_issue(o, a, b, 1'b0);
        respond($urandom_range(1, TMO - 1), o, a, b);
        release_done($urandom_range(1, 4));
      end
    end
    rr_random = 1'b0;
    #1;
    res_ready = 1'b1;
    wait_idle();
    check("scoreboard empty", sb.size(), 0);
    check("final op_count", op_count, exp_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
